// File: rtl/uwu_pkg.sv
// Shared types for the UART TX arbiter: FSM states, requester id, default timeout.
// Pure declarations; no latency or backpressure behaviour of its own.
package uwu_pkg;

   localparam int TIMEOUT_DEFAULT = 5210;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_t;

   typedef logic req_id_t;

   function automatic req_id_t other_id(input req_id_t id);
      return ~id;
   endfunction

endpackage

// File: rtl/uwu_tx_arbiter_if.sv
// Two requester byte channels plus the single TX byte channel; master = requester/sink side,
// slave = arbiter side. Valid/ready on every channel, byte moves when both are high.
interface uwu_tx_arbiter_if;

   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_last;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_last;
   logic       req1_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;

   modport master (
      output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, tx_ready,
      input  req0_ready, req1_ready, tx_valid, tx_data
   );

   modport slave (
      input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, tx_ready,
      output req0_ready, req1_ready, tx_valid, tx_data
   );

endinterface

// File: rtl/uwu_byte_reg.sv
// One-entry valid/ready byte register; 1-cycle latency, full throughput.
// Accepts a new byte whenever empty or draining this cycle; holds data stable while out_rdy=0.
module uwu_byte_reg (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_vld,
   input  logic [7:0] in_dat,
   output logic       in_rdy,
   output logic       out_vld,
   output logic [7:0] out_dat,
   input  logic       out_rdy
);

   assign in_rdy = !out_vld || out_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
         out_dat <= 8'h00;
      end else if (in_vld && in_rdy) begin
         out_vld <= 1'b1;
         out_dat <= in_dat;
      end else if (out_rdy) begin
         out_vld <= 1'b0;
      end
   end

endmodule

// File: rtl/uwu_tx_arbiter.sv
// Packet-atomic round-robin arbiter of two byte requesters onto one UART TX; 1 cycle to grant,
// then 1-cycle byte latency. Grantee's ready follows TX output space; idle lock revoked after timeout.
module uwu_tx_arbiter
   import uwu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   uwu_tx_arbiter_if.slave    bus,
   output logic               busy,
   output logic               active_id,
   output logic               err_timeout
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t       state, state_nxt;
   req_id_t          rr, rr_nxt;
   req_id_t          cur_id;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             err_nxt;
   logic             out_free;
   logic             sel_vld;
   logic             sel_last;
   logic [7:0]       sel_dat;
   logic             hs;

   assign cur_id   = (state == LOCK1);
   assign sel_vld  = ((state == LOCK0) && bus.req0_valid) || ((state == LOCK1) && bus.req1_valid);
   assign sel_dat  = cur_id ? bus.req1_data : bus.req0_data;
   assign sel_last = cur_id ? bus.req1_last : bus.req0_last;
   assign hs       = sel_vld && out_free;

   assign bus.req0_ready = (state == LOCK0) && out_free;
   assign bus.req1_ready = (state == LOCK1) && out_free;

   assign busy      = (state != IDLE) || bus.tx_valid;
   assign active_id = cur_id;

   uwu_byte_reg u_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (sel_vld),
      .in_dat  (sel_dat),
      .in_rdy  (out_free),
      .out_vld (bus.tx_valid),
      .out_dat (bus.tx_data),
      .out_rdy (bus.tx_ready)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr          <= 1'b0;
         cnt         <= '0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         rr          <= rr_nxt;
         cnt         <= cnt_nxt;
         err_timeout <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr;
      cnt_nxt   = cnt;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (bus.req0_valid && bus.req1_valid) state_nxt = rr ? LOCK1 : LOCK0;
            else if (bus.req0_valid)              state_nxt = LOCK0;
            else if (bus.req1_valid)              state_nxt = LOCK1;
         end
         LOCK0, LOCK1: begin
            if (hs) begin
               cnt_nxt = '0;
               if (sel_last) begin
                  state_nxt = IDLE;
                  rr_nxt    = other_id(cur_id);
               end
            end else if (!sel_vld) begin
               // Only an absent requester ages the lock; TX backpressure never does.
               if (cnt == CNT_LAST) begin
                  state_nxt = IDLE;
                  rr_nxt    = other_id(cur_id);
                  err_nxt   = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uwu_tx_arbiter.sv
// Directed and random stimulus for uwu_tx_arbiter with a short lock timeout of 16 cycles.
module tb_uwu_tx_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic busy, active_id, err_timeout;
   int   checks = 0;
   int   errors = 0;

   uwu_tx_arbiter_if bus ();

   uwu_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .busy        (busy),
      .active_id   (active_id),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent[2];
      int got[2];
      int pend[2];
      int to_cnt;
      int id;
      logic hs0, hs1;

      rst_n          = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
      bus.tx_ready   = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_tx_valid", 32'(bus.tx_valid), 0);
      chk("rst_tx_data", 32'(bus.tx_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err_timeout), 0);
      chk("rst_rdy", 32'({bus.req0_ready, bus.req1_ready}), 0);
      cyc(); cyc();
      rst_n = 1'b1;

      // single requester packet 55,77,55
      bus.req0_valid = 1'b1; bus.req0_data = 8'h55;
      cyc();
      chk("p1_rdy0", 32'(bus.req0_ready), 1);
      chk("p1_rdy1", 32'(bus.req1_ready), 0);
      chk("p1_busy", 32'(busy), 1);
      chk("p1_txv_lat", 32'(bus.tx_valid), 0);
      cyc();
      chk("p1_b0_v", 32'(bus.tx_valid), 1);
      chk("p1_b0", 32'(bus.tx_data), 32'h55);
      bus.req0_data = 8'h77;
      cyc();
      chk("p1_b1", 32'(bus.tx_data), 32'h77);
      bus.req0_data = 8'h55; bus.req0_last = 1'b1;
      cyc();
      chk("p1_b2", 32'(bus.tx_data), 32'h55);
      chk("p1_idle_rdy", 32'(bus.req0_ready), 0);
      chk("p1_drain_busy", 32'(busy), 1);
      bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
      cyc();
      chk("p1_txv_clr", 32'(bus.tx_valid), 0);
      chk("p1_busy_clr", 32'(busy), 0);

      // contention straight after reset
      rst_n = 1'b0; #1 rst_n = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_data = 8'hA0;
      bus.req1_valid = 1'b1; bus.req1_data = 8'hB0;
      cyc();
      chk("c_grant0", 32'(active_id), 0);
      chk("c_rdy0", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
      cyc();
      chk("c_a0", 32'(bus.tx_data), 32'hA0);
      bus.req0_data = 8'hA1; bus.req0_last = 1'b1;
      cyc();
      chk("c_a1", 32'(bus.tx_data), 32'hA1);
      chk("c_idle_rdy", 32'({bus.req0_ready, bus.req1_ready}), 0);
      bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
      cyc();
      chk("c_grant1", 32'(active_id), 1);
      chk("c_rdy1", 32'({bus.req0_ready, bus.req1_ready}), 32'b01);
      cyc();
      chk("c_b0", 32'(bus.tx_data), 32'hB0);
      bus.req1_data = 8'hB1; bus.req1_last = 1'b1;
      cyc();
      chk("c_b1", 32'(bus.tx_data), 32'hB1);
      bus.req0_valid = 1'b1; bus.req0_data = 8'hA2; bus.req0_last = 1'b1;
      bus.req1_data  = 8'hB2;
      cyc();
      chk("c_next_grant0", 32'(active_id), 0);
      cyc();
      chk("c_a2", 32'(bus.tx_data), 32'hA2);
      bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
      cyc();
      chk("c_grant1b", 32'(active_id), 1);
      cyc();
      chk("c_b2", 32'(bus.tx_data), 32'hB2);
      bus.req1_valid = 1'b0; bus.req1_last = 1'b0;
      cyc();
      chk("c_end_busy", 32'(busy), 0);

      // 20-cycle TX stall mid-packet
      bus.req0_valid = 1'b1; bus.req0_data = 8'hC0;
      cyc();
      cyc();
      chk("s_c0", 32'(bus.tx_data), 32'hC0);
      bus.tx_ready = 1'b0; bus.req0_data = 8'hC1;
      for (int k = 0; k < 20; k++) begin
         cyc();
         chk("s_hold_v", 32'(bus.tx_valid), 1);
         chk("s_hold_d", 32'(bus.tx_data), 32'hC0);
         chk("s_rdy0", 32'(bus.req0_ready), 0);
         chk("s_no_err", 32'(err_timeout), 0);
      end
      bus.tx_ready = 1'b1;
      cyc();
      chk("s_c1", 32'(bus.tx_data), 32'hC1);
      bus.req0_data = 8'hC2; bus.req0_last = 1'b1;
      cyc();
      chk("s_c2", 32'(bus.tx_data), 32'hC2);
      chk("s_c2_v", 32'(bus.tx_valid), 1);
      bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
      cyc();
      chk("s_end_v", 32'(bus.tx_valid), 0);

      // requester 1 abandons its packet; req0 waits
      bus.req1_valid = 1'b1; bus.req1_data = 8'hD0;
      cyc();
      chk("t_grant1", 32'(active_id), 1);
      cyc();
      chk("t_d0", 32'(bus.tx_data), 32'hD0);
      bus.req1_valid = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_data = 8'hE0; bus.req0_last = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         cyc();
         chk("t_wait_err", 32'(err_timeout), 0);
         chk("t_wait_lock", 32'(active_id), 1);
      end
      cyc();
      chk("t_err", 32'(err_timeout), 1);
      chk("t_idle_id", 32'(active_id), 0);
      chk("t_idle_rdy", 32'({bus.req0_ready, bus.req1_ready}), 0);
      cyc();
      chk("t_err_pulse", 32'(err_timeout), 0);
      chk("t_grant0", 32'(bus.req0_ready), 1);
      cyc();
      chk("t_e0", 32'(bus.tx_data), 32'hE0);
      bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
      cyc();
      chk("t_end_busy", 32'(busy), 0);

      // asynchronous reset with a byte in flight in LOCK1
      bus.req1_valid = 1'b1; bus.req1_data = 8'hF0; bus.tx_ready = 1'b0;
      cyc();
      chk("r_grant1", 32'(active_id), 1);
      cyc();
      chk("r_txv", 32'(bus.tx_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("r_async_txv", 32'(bus.tx_valid), 0);
      chk("r_async_busy", 32'(busy), 0);
      chk("r_async_id", 32'(active_id), 0);
      chk("r_async_dat", 32'(bus.tx_data), 0);
      bus.req1_valid = 1'b0; bus.tx_ready = 1'b1;
      cyc(); cyc();
      chk("r_hold_busy", 32'(busy), 0);
      rst_n = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_data = 8'h60; bus.req0_last = 1'b1;
      bus.req1_valid = 1'b1; bus.req1_data = 8'h61; bus.req1_last = 1'b1;
      cyc();
      chk("r_grant0", 32'({active_id, bus.req0_ready}), 32'b01);
      cyc();
      chk("r_g0", 32'(bus.tx_data), 32'h60);
      bus.req0_valid = 1'b0;
      cyc();
      chk("r_grant1b", 32'(active_id), 1);
      cyc();
      chk("r_h0", 32'(bus.tx_data), 32'h61);
      bus.req1_valid = 1'b0; bus.req0_last = 1'b0; bus.req1_last = 1'b0;
      cyc();

      // random single-byte packets, bit 7 tags the source, bits 6:0 its sequence number
      sent = '{0, 0}; got = '{0, 0}; pend = '{0, 0}; to_cnt = 0;
      bus.req0_last = 1'b1; bus.req1_last = 1'b1;
      for (int c = 0; c < 6000 && (got[0] < 100 || got[1] < 100); c++) begin
         @(negedge clk);
         hs0 = bus.req0_valid && bus.req0_ready;
         hs1 = bus.req1_valid && bus.req1_ready;
         if (bus.tx_valid && bus.tx_ready) begin
            id = int'(bus.tx_data[7]);
            chk("rnd_order", 32'(bus.tx_data[6:0]), 32'(got[id] % 128));
            got[id]++;
         end
         if (hs1 && bus.req0_valid) begin
            pend[0]++;
            chk("rnd_fair0", 32'(pend[0] <= 1), 1);
         end
         if (hs0 && bus.req1_valid) begin
            pend[1]++;
            chk("rnd_fair1", 32'(pend[1] <= 1), 1);
         end
         if (hs0) pend[0] = 0;
         if (hs1) pend[1] = 0;
         if (err_timeout) to_cnt++;
         cyc();
         if (hs0) begin sent[0]++; bus.req0_valid = 1'b0; end
         if (hs1) begin sent[1]++; bus.req1_valid = 1'b0; end
         if (!bus.req0_valid && sent[0] < 100 && $urandom_range(0, 2) != 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = {1'b0, 7'(sent[0])};
         end
         if (!bus.req1_valid && sent[1] < 100 && $urandom_range(0, 2) != 0) begin
            bus.req1_valid = 1'b1;
            bus.req1_data  = {1'b1, 7'(sent[1])};
         end
         bus.tx_ready = ($urandom_range(0, 3) != 0);
      end
      chk("rnd_got0", 32'(got[0]), 100);
      chk("rnd_got1", 32'(got[1]), 100);
      chk("rnd_no_timeout", 32'(to_cnt), 0);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.tx_ready = 1'b1;
      cyc(); cyc();
      chk("rnd_end_busy", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uwu_tx_arbiter.md
UWU_TX_ARBITER -- requirements
Module: uwu_tx_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 5210, mid-packet idle cycles before a lock is revoked (about 10 byte-times at 6 MHz / 115200 baud).
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req0_valid / req1_valid  in  1 each  requester byte valid.
REQ-005 SHALL have ports: req0_data / req1_data  in  8 each  requester byte.
REQ-006 SHALL have ports: req0_last / req1_last  in  1 each  byte ends the requester's packet.
REQ-007 SHALL have ports: req0_ready / req1_ready  out  1 each  byte accepted when valid and ready are both high.
REQ-008 SHALL have ports: tx_valid  out  1, tx_data  out  8, tx_ready  in  1; byte stream to the single UART transmitter.
REQ-009 SHALL have ports: busy  out  1, active_id  out  1, err_timeout  out  1; status.

Function
REQ-010 SHALL share one UART TX byte channel between two requesters, with packet atomicity and round-robin fairness.
REQ-011 SHALL implement FSM states IDLE, LOCK0 and LOCK1.
REQ-012 SHALL, in IDLE, move to LOCKi on the next edge when only reqi_valid=1.
REQ-013 SHALL, in IDLE with both valids high, grant the requester selected by the rr pointer.
REQ-014 SHALL define the rr pointer as the requester not most recently released; its reset value is 0.
REQ-015 SHALL, in IDLE, hold req0_ready=req1_ready=0, so arbitration costs exactly 1 cycle.
REQ-016 SHALL define out_free = !tx_valid || tx_ready.
REQ-017 SHALL, in LOCKi, drive reqi_ready=out_free and hold the other ready at 0.
REQ-018 SHALL, on a LOCKi handshake, load tx_data<=reqi_data and set tx_valid=1 on the next edge.
REQ-019 SHALL give 1-cycle input-to-output latency with full throughput of 1 byte/cycle while tx_ready=1.
REQ-020 SHALL hold tx_valid and tx_data stable until tx_ready=1.
REQ-021 SHALL clear tx_valid when tx_ready=1 and no new handshake occurs in that cycle.
REQ-022 SHALL, on a LOCKi handshake with reqi_last=1, return to IDLE and point rr at the other requester.
REQ-023 SHALL allow the output byte of a just-closed packet to drain while IDLE arbitrates.
REQ-024 SHALL, in LOCKi, increment a timeout counter each cycle reqi_valid=0, and clear it on every handshake and on every LOCK entry.
REQ-025 SHALL NOT count cycles stalled by tx_ready=0 while reqi_valid=1.
REQ-026 SHALL, when the counter reaches TIMEOUT_CYCLES-1, go to IDLE, point rr at the other requester, and pulse err_timeout high for exactly 1 cycle.
REQ-027 SHALL size the counter as $clog2(TIMEOUT_CYCLES) bits with no wrap-around.
REQ-028 SHALL treat timeout and handshake as mutually exclusive in one cycle (timeout needs valid=0, handshake needs valid=1); no extra priority rule applies.
REQ-029 SHALL drive busy = (state!=IDLE) || tx_valid.
REQ-030 SHALL drive active_id = 1 in LOCK1 and 0 otherwise.
REQ-031 SHALL allow requester data to change while its ready is low; data is sampled only at a handshake.

Reset
REQ-032 SHALL, on rst_n=0, immediately (asynchronously) set state=IDLE, rr=0, counter=0, tx_valid=0, tx_data=8'h00 and err_timeout=0.
REQ-033 SHALL drop any in-flight byte or partial packet on reset.
REQ-034 SHALL leave all outputs at reset values while rst_n=0, and release synchronously to clk.

Structure
REQ-035 SHALL place the arb_state_t enum (IDLE/LOCK0/LOCK1), the req_id_t typedef (1 bit) and the TIMEOUT_DEFAULT constant (5210) in shared package uwu_pkg.
REQ-036 SHALL implement the output register as sub-module uwu_byte_reg (valid/ready one-entry register, 8-bit data); the FSM, rr pointer and timeout counter stay in uwu_tx_arbiter.

Verification
REQ-037 SHALL cover: req0 packet 8'h55,8'h77,8'h55 (last on 3rd) with tx_ready=1 -> tx_data 55,77,55 on consecutive cycles, first byte 2 cycles after req0_valid rises, then IDLE.
REQ-038 SHALL cover: req0 and req1 valid in the same cycle after reset, 2-byte packets each -> req0 packet first, then req1, with no interleaving; next contention grants req0.
REQ-039 SHALL cover: tx_ready=0 for 20 cycles mid-packet -> tx_data held, no err_timeout, no byte lost or duplicated.
REQ-040 SHALL cover: req1 drops valid mid-packet with TIMEOUT_CYCLES=16 -> err_timeout high exactly once 16 cycles later, state IDLE, req0 (waiting) granted next.
REQ-041 SHALL cover: rst_n asserted while tx_valid=1 in LOCK1 -> tx_valid=0 and busy=0 immediately, without a clock edge; after release the first contention grants req0.
REQ-042 SHALL cover: 200 random single-byte packets from both requesters with random tx_ready -> scoreboard shows per-requester byte order kept, no starvation, and grants alternating whenever both are valid.
